// File: rtl/interpolator_multi.sv
// Per-channel slew-rate limiter for intensity and phase: clears its state memory after reset, then
// steps each channel toward its streamed target by at most the per-frame rate, with 3-cycle latency.
module interpolator_multi #(
  parameter int unsigned Depth  = 249,
  parameter int unsigned IntW   = 16,
  parameter int unsigned PhW    = 16,
  parameter int unsigned PhOutW = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              din_valid_i,
  input  logic              bypass_i,
  input  logic [IntW-1:0]   update_rate_intensity_i,
  input  logic [PhW-1:0]    update_rate_phase_i,
  input  logic [IntW-1:0]   intensity_i,
  input  logic [PhW-1:0]    phase_i,
  output logic [IntW-1:0]   intensity_o,
  output logic [PhOutW-1:0] phase_o,
  output logic              dout_valid_o,
  output logic              dout_last_o,
  output logic              busy_o
);

  localparam int unsigned    ChW    = $clog2(Depth);
  localparam logic [ChW-1:0] LastCh = ChW'(Depth - 1);

  typedef enum logic [1:0] {StClear, StIdle, StRun} state_e;

  state_e            st_q;
  logic [ChW-1:0]    ch_q;
  logic              busy_q;
  logic              byp_q;
  logic [IntW-1:0]   rate_int_q;
  logic [PhW-1:0]    rate_ph_q;

  logic              s1_valid_q;
  logic [ChW-1:0]    s1_ch_q;
  logic [IntW-1:0]   s1_int_q;
  logic [PhW-1:0]    s1_ph_q;

  logic              s2_valid_q;
  logic              s2_last_q;
  logic [IntW-1:0]   s2_int_q;
  logic [PhOutW-1:0] s2_ph_q;

  logic              out_valid_q;
  logic              out_last_q;
  logic [IntW-1:0]   out_int_q;
  logic [PhOutW-1:0] out_ph_q;

  logic [IntW-1:0]   mem_int_q [Depth];
  logic [PhW-1:0]    mem_ph_q  [Depth];

  logic [IntW-1:0]       cur_int, int_d;
  logic [PhW-1:0]        cur_ph, ph_diff, ph_d;
  logic signed [IntW+1:0] int_delta, int_rate, int_step;
  logic signed [PhW+1:0]  ph_delta, ph_rate, ph_step;

  always_comb begin
    cur_int   = mem_int_q[s1_ch_q];
    cur_ph    = mem_ph_q[s1_ch_q];
    int_delta = $signed({2'b00, s1_int_q}) - $signed({2'b00, cur_int});
    int_rate  = $signed({2'b00, rate_int_q});
    if (int_delta > int_rate)       int_step = int_rate;
    else if (int_delta < -int_rate) int_step = -int_rate;
    else                            int_step = int_delta;

    ph_diff = s1_ph_q - cur_ph;
    // Exactly half a circle away resolves forward, so keep it positive.
    if (ph_diff == {1'b1, {(PhW-1){1'b0}}}) ph_delta = $signed({2'b00, ph_diff});
    else                                    ph_delta = $signed({{2{ph_diff[PhW-1]}}, ph_diff});
    ph_rate = $signed({2'b00, rate_ph_q});
    if (ph_delta > ph_rate)       ph_step = ph_rate;
    else if (ph_delta < -ph_rate) ph_step = -ph_rate;
    else                          ph_step = ph_delta;

    int_d = byp_q ? s1_int_q : IntW'($unsigned({2'b00, cur_int}) + $unsigned(int_step));
    ph_d  = byp_q ? s1_ph_q  : PhW'($unsigned({2'b00, cur_ph}) + $unsigned(ph_step));
  end

  // A channel recurs at least Depth beats later, so the write lands before its next read.
  always_ff @(posedge clk_i) begin
    if (st_q == StClear) begin
      mem_int_q[ch_q] <= '0;
      mem_ph_q[ch_q]  <= '0;
    end else if (s1_valid_q) begin
      mem_int_q[s1_ch_q] <= int_d;
      mem_ph_q[s1_ch_q]  <= ph_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q        <= StClear;
      ch_q        <= '0;
      busy_q      <= 1'b1;
      byp_q       <= 1'b0;
      rate_int_q  <= '0;
      rate_ph_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_ch_q     <= '0;
      s1_int_q    <= '0;
      s1_ph_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_int_q    <= '0;
      s2_ph_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_int_q   <= '0;
      out_ph_q    <= '0;
    end else begin
      s1_valid_q <= 1'b0;
      unique case (st_q)
        StClear: begin
          if (ch_q == LastCh) begin
            ch_q   <= '0;
            st_q   <= StIdle;
            busy_q <= 1'b0;
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        StIdle, StRun: begin
          if (din_valid_i) begin
            s1_valid_q <= 1'b1;
            s1_ch_q    <= ch_q;
            s1_int_q   <= intensity_i;
            s1_ph_q    <= phase_i;
            // Frame parameters are sampled only with channel 0.
            if (st_q == StIdle) begin
              byp_q      <= bypass_i;
              rate_int_q <= update_rate_intensity_i;
              rate_ph_q  <= update_rate_phase_i;
            end
            if (ch_q == LastCh) begin
              ch_q <= '0;
              st_q <= StIdle;
            end else begin
              ch_q <= ch_q + 1'b1;
              st_q <= StRun;
            end
          end
        end
        default: st_q <= StClear;
      endcase

      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_valid_q && (s1_ch_q == LastCh);
      s2_int_q    <= int_d;
      s2_ph_q     <= ph_d[PhW-1 -: PhOutW];

      out_valid_q <= s2_valid_q;
      out_last_q  <= s2_last_q;
      out_int_q   <= s2_valid_q ? s2_int_q : '0;
      out_ph_q    <= s2_valid_q ? s2_ph_q : '0;
    end
  end

  assign intensity_o  = out_int_q;
  assign phase_o      = out_ph_q;
  assign dout_valid_o = out_valid_q;
  assign dout_last_o  = out_last_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_interpolator_multi.sv
// Bench for interpolator_multi: directed vector table, reset/stall sequences and a randomized
// scoreboard against an arithmetic reference model.
module tb_interpolator_multi;
  localparam int unsigned Depth  = 4;
  localparam int unsigned IntW   = 16;
  localparam int unsigned PhW    = 16;
  localparam int unsigned PhOutW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              din_valid = 1'b0;
  logic              bypass = 1'b0;
  logic [IntW-1:0]   rate_int = '0;
  logic [PhW-1:0]    rate_ph = '0;
  logic [IntW-1:0]   int_in = '0;
  logic [PhW-1:0]    ph_in = '0;
  logic [IntW-1:0]   int_out;
  logic [PhOutW-1:0] ph_out;
  logic              dout_valid, dout_last, busy;

  always #5 clk = ~clk;

  interpolator_multi #(.Depth(Depth), .IntW(IntW), .PhW(PhW), .PhOutW(PhOutW)) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .din_valid_i            (din_valid),
    .bypass_i               (bypass),
    .update_rate_intensity_i(rate_int),
    .update_rate_phase_i    (rate_ph),
    .intensity_i            (int_in),
    .phase_i                (ph_in),
    .intensity_o            (int_out),
    .phase_o                (ph_out),
    .dout_valid_o           (dout_valid),
    .dout_last_o            (dout_last),
    .busy_o                 (busy)
  );

  typedef struct {bit byp; int ri; int rp; int ti; int tp; int ei; int ep;} vec_t;
  typedef struct {int cyc; int iv; int pv; bit last;} exp_t;

  vec_t   vecs[$];
  exp_t   q[$];
  int     cyc = 0, n_tests = 0, n_fail = 0, mch = 0;
  longint m_int[Depth], m_ph[Depth], m_ri, m_rp;
  bit     m_byp;

  function automatic longint lim(longint d, longint r);
    if (d > r) return r;
    if (d < -r) return -r;
    return d;
  endfunction

  function automatic longint model_ph(longint cur, longint tgt, longint r);
    longint full = longint'(1) << PhW;
    longint d = (tgt - cur) % full;
    longint n;
    if (d < 0) d += full;
    if (d > full / 2) d -= full;
    n = (cur + lim(d, r)) % full;
    if (n < 0) n += full;
    return n;
  endfunction

  // One clock; outputs are sampled at the falling edge and checked against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (dout_valid) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_dout @%0d: got int=%h ph=%h, required no output", cyc, int_out,
                 ph_out);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || int_out != IntW'(e.iv) || ph_out != PhOutW'(e.pv)
            || dout_last != e.last) begin
          n_fail++;
          $display("FAIL beat @%0d: got int=%h ph=%h last=%b, required cyc=%0d int=%h ph=%h last=%b",
                   cyc, int_out, ph_out, dout_last, e.cyc, e.iv, e.pv, e.last);
        end
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      n_tests++;
      n_fail++;
      e = q.pop_front();
      $display("FAIL missing_dout @%0d: got dout_valid=0, required int=%h ph=%h", cyc, e.iv, e.pv);
    end
  endtask

  task automatic drive_beat(bit byp, int ri, int rp, int ti, int tp, bit use_tab, int ei, int ep);
    exp_t e;
    longint ni, np;
    if (mch == 0) begin
      m_byp = byp;
      m_ri  = ri;
      m_rp  = rp;
    end
    ni = m_byp ? longint'(ti) : m_int[mch] + lim(longint'(ti) - m_int[mch], m_ri);
    np = m_byp ? longint'(tp) : model_ph(m_ph[mch], tp, m_rp);
    m_int[mch] = ni;
    m_ph[mch]  = np;
    e.cyc  = cyc + 3;
    e.iv   = use_tab ? ei : int'(ni);
    e.pv   = use_tab ? ep : int'(np >> (PhW - PhOutW));
    e.last = (mch == Depth - 1);
    q.push_back(e);
    mch = (mch + 1) % Depth;
    din_valid = 1'b1;
    bypass    = byp;
    rate_int  = IntW'(ri);
    rate_ph   = PhW'(rp);
    int_in    = IntW'(ti);
    ph_in     = PhW'(tp);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    int cnt;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    q.delete();
    mch = 0;
    for (int i = 0; i < Depth; i++) begin
      m_int[i] = 0;
      m_ph[i]  = 0;
    end
    tick();
    tick();
    n_tests++;
    if (dout_valid || dout_last || int_out != 0 || ph_out != 0 || !busy) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b last=%b int=%h ph=%h busy=%b, required 0 0 0 0 1",
               dout_valid, dout_last, int_out, ph_out, busy);
    end
    rst_n = 1'b1;
    cnt   = 1;
    // Beats offered while clearing must be dropped.
    for (int i = 0; i < 20; i++) begin
      din_valid = 1'b1;
      int_in    = IntW'($urandom);
      ph_in     = PhW'($urandom);
      tick();
      if (busy) cnt++;
      else break;
    end
    din_valid = 1'b0;
    n_tests++;
    if (cnt != Depth) begin
      n_fail++;
      $display("FAIL busy_cycles: got %0d, required %0d", cnt, Depth);
    end
  endtask

  task automatic add(bit byp, int ri, int rp, int ti, int tp, int ei, int ep);
    vec_t v;
    v.byp = byp; v.ri = ri; v.rp = rp; v.ti = ti; v.tp = tp; v.ei = ei; v.ep = ep;
    vecs.push_back(v);
  endtask

  function automatic int rand_rate();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return int'($urandom_range(0, 'h200));
      2:       return int'($urandom & 'hFFFF);
      default: return 'hFFFF;
    endcase
  endfunction

  initial begin
    // Frame A: zero state, rate 0x100.
    for (int i = 0; i < 4; i++) add(0, 'h100, 0, 'h1000, 0, 'h0100, 'h00);
    // Frame B: bypass loads targets directly.
    add(1, 0, 0, 'h1234, 'hFF00, 'h1234, 'hFF);
    add(1, 0, 0, 'hABCD, 'h0000, 'hABCD, 'h00);
    add(1, 0, 0, 'h0000, 'h1000, 'h0000, 'h10);
    add(1, 0, 0, 'hFFFF, 'h8000, 'hFFFF, 'h80);
    // Frames C..G: phase wrap 0xFF00 -> 0x0100, tie at rate 0x80, intensity clamp both ways.
    add(0, 'h1000, 'h80, 'h1234, 'h0100, 'h1234, 'hFF);
    add(0, 'h1000, 'h80, 'h0000, 'h8000, 'h9BCD, 'h00);
    add(0, 'h1000, 'h80, 'hFFFF, 'h0F00, 'h1000, 'h0F);
    add(0, 'h1000, 'h80, 'hFFFF, 'h8040, 'hFFFF, 'h80);
    add(0, 'h1000, 'h80, 'h1234, 'h0100, 'h1234, 'h00);
    add(0, 'h1000, 'h80, 'h0000, 'h8000, 'h8BCD, 'h01);
    add(0, 'h1000, 'h80, 'hFFFF, 'h0F00, 'h2000, 'h0F);
    add(0, 'h1000, 'h80, 'hFFFF, 'h8040, 'hFFFF, 'h80);
    add(0, 'h1000, 'h80, 'h1234, 'h0100, 'h1234, 'h00);
    add(0, 'h1000, 'h80, 'h0000, 'h8000, 'h7BCD, 'h01);
    add(0, 'h1000, 'h80, 'hFFFF, 'h0F00, 'h3000, 'h0F);
    add(0, 'h1000, 'h80, 'hFFFF, 'h8040, 'hFFFF, 'h80);
    add(0, 'h1000, 'h80, 'h1234, 'h0100, 'h1234, 'h01);
    add(0, 'h1000, 'h80, 'h0000, 'h8000, 'h6BCD, 'h02);
    add(0, 'h1000, 'h80, 'hFFFF, 'h0F00, 'h4000, 'h0F);
    add(0, 'h1000, 'h80, 'hFFFF, 'h8040, 'hFFFF, 'h80);
    add(0, 'h1000, 'h80, 'h1234, 'h0100, 'h1234, 'h01);
    add(0, 'h1000, 'h80, 'h0000, 'h8000, 'h5BCD, 'h02);
    add(0, 'h1000, 'h80, 'hFFFF, 'h0F00, 'h5000, 'h0F);
    add(0, 'h1000, 'h80, 'hFFFF, 'h8040, 'hFFFF, 'h80);
    // Frame H: bypass to known values.
    add(1, 0, 0, 'h10, 0, 'h10, 'h00);
    add(1, 0, 0, 'h20, 0, 'h20, 'h00);
    add(1, 0, 0, 'h30, 0, 'h30, 'h00);
    add(1, 0, 0, 'h40, 0, 'h40, 'h00);
    // Frame I: intensity rate 0 holds; phase tie at rate 0x1000 goes forward.
    add(0, 0, 'h1000, 'hFFFF, 'h8000, 'h10, 'h10);
    add(0, 0, 'h1000, 'hFFFF, 'h8000, 'h20, 'h10);
    add(0, 0, 'h1000, 'hFFFF, 'h7000, 'h30, 'h10);
    add(0, 0, 'h1000, 'hFFFF, 'h9000, 'h40, 'hF0);
    // Frame J: full rates reach targets exactly, including half-circle ties.
    add(0, 'hFFFF, 'hFFFF, 'hFFFF, 'h9000, 'hFFFF, 'h90);
    add(0, 'hFFFF, 'hFFFF, 'h0000, 'h1000, 'h0000, 'h10);
    add(0, 'hFFFF, 'hFFFF, 'h8000, 'h0000, 'h8000, 'h00);
    add(0, 'hFFFF, 'hFFFF, 'h0001, 'h7000, 'h0001, 'h70);

    do_reset();
    foreach (vecs[i])
      drive_beat(vecs[i].byp, vecs[i].ri, vecs[i].rp, vecs[i].ti, vecs[i].tp, 1'b1, vecs[i].ei,
                 vecs[i].ep);
    repeat (6) tick();

    // Reset two beats into a frame: in-flight beats vanish and the state is zero again.
    drive_beat(1, 0, 0, 'h7777, 'h7777, 1'b0, 0, 0);
    drive_beat(1, 0, 0, 'h7777, 'h7777, 1'b0, 0, 0);
    do_reset();
    for (int c = 0; c < Depth; c++) drive_beat(0, 0, 0, 'hFFFF, 'hFFFF, 1'b1, 0, 0);
    repeat (6) tick();

    // Random frames with stalls and per-beat rate/bypass changes (only channel 0's apply).
    for (int f = 0; f < 1000; f++) begin
      for (int c = 0; c < Depth; c++) begin
        int gap, tp;
        gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0;
        for (int g = 0; g < gap; g++) begin
          bypass   = 1'($urandom);
          rate_int = IntW'($urandom);
          int_in   = IntW'($urandom);
          ph_in    = PhW'($urandom);
          tick();
        end
        tp = ($urandom_range(0, 3) == 0) ? int'((m_ph[mch] + 'h8000) % 'h10000)
                                         : int'($urandom & 'hFFFF);
        drive_beat($urandom_range(0, 7) == 0, rand_rate(), rand_rate(), int'($urandom & 'hFFFF),
                   tp, 1'b0, 0, 0);
      end
    end
    repeat (8) tick();

    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outputs outstanding, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
